// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 host transmitter and the receiver that shares its pins.
package ps2_pkg;

  localparam int PS2_BITS = 8;
  localparam int STOP_IDX = 9;

  // Default timing at 25 MHz: 100 us inhibit, 15 ms device-clock timeout.
  localparam int INHIBIT_CYCLES_DEF = 2500;
  localparam int TIMEOUT_CYCLES_DEF = 375000;
  localparam int TW_DEF             = 19;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] INHIBIT = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] SHIFT   = 3'd3;
  localparam logic [2:0] ACK     = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  function automatic logic odd_parity(input logic [PS2_BITS-1:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchroniser for the PS/2 clock and data pins plus a falling-edge
// detector on the synchronised clock. The receiver uses the same block.
module ps2_sync (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_dat,
  output logic dat_s,
  output logic fall
);

  logic clk_meta;
  logic clk_s;
  logic prev_clk_s;
  logic dat_meta;

  // Idle bus is high, so reset to 1 to avoid a false edge after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_meta   <= 1'b1;
      clk_s      <= 1'b1;
      prev_clk_s <= 1'b1;
      dat_meta   <= 1'b1;
      dat_s      <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk;
      clk_s      <= clk_meta;
      prev_clk_s <= clk_s;
      dat_meta   <= ps2_dat;
      dat_s      <= dat_meta;
    end
  end

  assign fall = prev_clk_s & ~clk_s;

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame shifted out on
// device clock falls, ACK check and a device-clock timeout.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int TW             = TW_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [PS2_BITS-1:0] data,
  input  logic                send,
  output logic                busy,
  output logic                done,
  output logic                ack,
  output logic                error,
  input  logic                ps2_clk,
  input  logic                ps2_dat,
  output logic                ps2_clk_oe,
  output logic                ps2_dat_oe,
  output logic [2:0]          dbg_state
);

  // Handshake: send is a one-cycle strobe accepted only when busy=0 and the
  // FSM is idle; busy stays high until the cycle done or error pulses, and any
  // send seen while busy (or in the done cycle) is dropped, never queued.

  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    PAR_IDX      = 4'(PS2_BITS);
  localparam logic [3:0]    LAST_IDX     = 4'(STOP_IDX);

  logic [2:0]          state;
  logic [TW-1:0]       timer;
  logic [3:0]          bit_cnt;
  logic [PS2_BITS-1:0] shreg;
  logic                par;
  logic                dat_s;
  logic                fall;

  ps2_sync u_sync (
    .clock   (clock),
    .reset   (reset),
    .ps2_clk (ps2_clk),
    .ps2_dat (ps2_dat),
    .dat_s   (dat_s),
    .fall    (fall)
  );

  assign dbg_state = state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par        <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ack        <= 1'b0;
      error      <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            shreg      <= data;
            par        <= odd_parity(data);
            busy       <= 1'b1;
            ack        <= 1'b0;
            ps2_clk_oe <= 1'b1;
            timer      <= '0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer == INHIBIT_LAST) begin
            ps2_dat_oe <= 1'b1;
            state      <= START;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        START: begin
          ps2_clk_oe <= 1'b0;
          timer      <= '0;
          bit_cnt    <= '0;
          state      <= SHIFT;
        end
        SHIFT: begin
          // A fall on the same cycle as the timeout still advances the frame.
          if (fall) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt < PAR_IDX) begin
              ps2_dat_oe <= ~shreg[bit_cnt[2:0]];
            end else if (bit_cnt == PAR_IDX) begin
              ps2_dat_oe <= ~par;
            end else if (bit_cnt == LAST_IDX) begin
              ps2_dat_oe <= 1'b0;
              state      <= ACK;
            end
          end else if (timer == TIMEOUT_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            timer      <= '0;
            state      <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ACK: begin
          if (fall) begin
            ack   <= ~dat_s;
            done  <= 1'b1;
            busy  <= 1'b0;
            timer <= '0;
            state <= DONE;
          end else if (timer == TIMEOUT_LAST) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b1;
            timer      <= '0;
            state      <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: models an open-drain PS/2 device and scoreboards each frame.
module tb_ps2_tx;

  localparam int PERIOD = 10;
  localparam int HALF   = 8;

  logic       clock;
  logic       reset;
  logic [7:0] data;
  logic       send;
  logic       busy, done, ack, error;
  logic       ps2_clk_oe, ps2_dat_oe;
  logic [2:0] dbg_state;

  logic dev_clk, dev_dat;
  logic ps2_clk_pin, ps2_dat_pin;
  assign ps2_clk_pin = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_pin = dev_dat & ~ps2_dat_oe;

  ps2_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(200), .TW(19)) dut (
    .clock      (clock),
    .reset      (reset),
    .data       (data),
    .send       (send),
    .busy       (busy),
    .done       (done),
    .ack        (ack),
    .error      (error),
    .ps2_clk    (ps2_clk_pin),
    .ps2_dat    (ps2_dat_pin),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #(PERIOD/2) clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // scoreboard word: {error, ack, byte, parity, stop}
  logic [11:0] exp_q[$];
  logic [7:0]  cap_byte;
  logic        cap_par, cap_stop;
  time         last_fall_t;

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    data = b;
    send = 1'b1;
    @(negedge clock);
    send = 1'b0;
  endtask

  task automatic device_frame(input int n_clk, input bit give_ack);
    int t;
    logic [10:0] bits;
    bits = '0;
    t = 0;
    while (!ps2_clk_oe && t < 200) begin @(negedge clock); t++; end
    check_eq("req_clk_low", ps2_clk_oe, 1);
    t = 0;
    while (ps2_clk_oe && t < 200) begin @(negedge clock); t++; end
    check_eq("req_clk_released", ps2_clk_oe, 0);
    check_eq("start_bit", ps2_dat_pin, 0);
    for (int i = 0; i < n_clk; i++) begin
      if (i == 10 && give_ack) dev_dat = 1'b0;
      repeat (HALF) @(negedge clock);
      dev_clk = 1'b0;
      last_fall_t = $time;
      repeat (HALF) @(negedge clock);
      dev_clk = 1'b1;
      if (i <= 9) bits[i] = ps2_dat_pin;
      if (i == 9) begin
        cap_byte = bits[7:0];
        cap_par  = bits[8];
        cap_stop = bits[9];
      end
      dev_dat = 1'b1;
    end
  endtask

  // monitor: each done/error pulse pops one expected response
  logic [11:0] act_w, exp_w;
  always @(negedge clock) begin
    if (!reset && (done || error)) begin
      if (error) act_w = {1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
      else       act_w = {1'b0, ack, cap_byte, cap_par, cap_stop};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got %03h expected no response", act_w);
      end else begin
        exp_w = exp_q.pop_front();
        check_eq("sb_response", act_w, exp_w);
      end
    end
  end

  // monitor: clock held low alone for exactly 20 cycles before the start bit
  int inhib_run = 0;
  always @(negedge clock) begin
    if (reset) inhib_run = 0;
    else if (ps2_clk_oe && !ps2_dat_oe) inhib_run++;
    else begin
      if (ps2_clk_oe && ps2_dat_oe && inhib_run != 0) check_eq("inhibit_len", inhib_run, 20);
      inhib_run = 0;
    end
  end

  int t;
  int delta;

  initial begin
    reset = 1'b1; send = 1'b0; data = 8'h00;
    dev_clk = 1'b1; dev_dat = 1'b1;
    cap_byte = 8'h00; cap_par = 1'b0; cap_stop = 1'b0; last_fall_t = 0;
    repeat (3) @(negedge clock);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ack", ack, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_clk_oe", ps2_clk_oe, 0);
    check_eq("rst_dat_oe", ps2_dat_oe, 0);
    check_eq("rst_state", dbg_state, 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 0xED, six ones -> parity 1, device ACKs
    exp_q.push_back({1'b0, 1'b1, 8'hED, 1'b1, 1'b1});
    send_byte(8'hED);
    device_frame(11, 1'b1);
    repeat (10) @(negedge clock);

    // 0x00 -> parity 1, device omits ACK
    exp_q.push_back({1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
    send_byte(8'h00);
    device_frame(11, 1'b0);
    repeat (10) @(negedge clock);

    // device stops after 4 bits -> timeout
    exp_q.push_back({1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    send_byte(8'h96);
    device_frame(4, 1'b0);
    t = 0;
    while (!error && t < 400) begin @(negedge clock); t++; end
    check_eq("timeout_seen", error, 1);
    delta = int'(($time - last_fall_t) / PERIOD);
    check_eq("timeout_delay_window", (delta >= 202 && delta <= 204), 1);
    check_eq("timeout_clk_oe", ps2_clk_oe, 0);
    check_eq("timeout_dat_oe", ps2_dat_oe, 0);
    check_eq("timeout_busy", busy, 0);
    repeat (10) @(negedge clock);

    // send of 0x55 while busy is ignored; frame carries 0x3C (four ones -> parity 1)
    exp_q.push_back({1'b0, 1'b1, 8'h3C, 1'b1, 1'b1});
    send_byte(8'h3C);
    fork
      device_frame(11, 1'b1);
      begin
        repeat (5) @(negedge clock);
        data = 8'h55;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
      end
    join
    repeat (60) @(negedge clock);
    check_eq("ignored_send_no_restart", busy, 0);
    check_eq("ignored_send_idle", dbg_state, 0);

    // reset while shifting bit 3 of 0xA5 (bit 3 = 0, so data is pulled low)
    send_byte(8'hA5);
    device_frame(4, 1'b0);
    check_eq("pre_reset_dat_oe", ps2_dat_oe, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_eq("mid_reset_clk_oe", ps2_clk_oe, 0);
    check_eq("mid_reset_dat_oe", ps2_dat_oe, 0);
    check_eq("mid_reset_busy", busy, 0);
    repeat (5) @(negedge clock);

    // 0xFF (parity 1) then back-to-back 0xF4 (five ones -> parity 0)
    exp_q.push_back({1'b0, 1'b1, 8'hFF, 1'b1, 1'b1});
    exp_q.push_back({1'b0, 1'b1, 8'hF4, 1'b0, 1'b1});
    send_byte(8'hFF);
    fork
      device_frame(11, 1'b1);
      begin
        int tw;
        tw = 0;
        while (!done && tw < 1000) begin @(negedge clock); tw++; end
        check_eq("b2b_first_done", done, 1);
        @(negedge clock);
        data = 8'hF4;
        send = 1'b1;
        @(negedge clock);
        send = 1'b0;
      end
    join
    device_frame(11, 1'b1);
    repeat (20) @(negedge clock);

    check_eq("sb_queue_drained", exp_q.size(), 0);
    check_eq("final_busy", busy, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
